// File: rtl/fire_sched_pkg.sv
// Shared state encoding and default constants for the fire-hazard scheduler,
// the fire movers and the score display.
package fire_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    ACTIVE    = 3'd2,
    HIT_FLUSH = 3'd3,
    GAMEOVER  = 3'd4
  } state_t;

  localparam int NUM_SLOTS_DEF   = 2;
  localparam int WIN_LO_DEF      = 292;
  localparam int WIN_HI_DEF      = 360;
  localparam int TICK_DIV_DEF    = 12;
  localparam int COOLDOWN_DEF    = 15;
  localparam int DEAD_OFFSET_DEF = 10;
  localparam int DEAD_MAX_DEF    = 500;

endpackage

// File: rtl/frame_tick_div.sv
// Brings the asynchronous frame clock into the Clk domain and divides its
// rising edges down to the move_tick pacing pulse.
module frame_tick_div
  import fire_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  input  logic en,
  output logic move_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic             frame_p0, frame_p1, frame_p2;
  logic             frame_tick;
  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      frame_p0   <= 1'b0;
      frame_p1   <= 1'b0;
      frame_p2   <= 1'b0;
      frame_tick <= 1'b0;
      tick_cnt   <= '0;
      move_tick  <= 1'b0;
    end else begin
      // p0/p1 synchronise, p2 holds the previous level for edge detection
      frame_p0   <= frame_clk;
      frame_p1   <= frame_p0;
      frame_p2   <= frame_p1;
      frame_tick <= frame_p1 & ~frame_p2;
      move_tick  <= 1'b0;
      if (!en) begin
        tick_cnt <= '0;
      end else if (frame_tick) begin
        if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
          tick_cnt  <= '0;
          move_tick <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fire_scheduler.sv
// Spawn, pacing and hit-penalty sequencer for the fire-hazard sprites; the
// movers only move and report hit/offscreen back here.
module fire_scheduler
  import fire_sched_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int WIN_LO      = WIN_LO_DEF,
  parameter int WIN_HI      = WIN_HI_DEF,
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int COOLDOWN    = COOLDOWN_DEF,
  parameter int DEAD_OFFSET = DEAD_OFFSET_DEF,
  parameter int DEAD_MAX    = DEAD_MAX_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [8:0]           BG_step,
  input  logic                 restart,
  input  logic [NUM_SLOTS-1:0] hit,
  input  logic [NUM_SLOTS-1:0] offscreen,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] spawn_pulse,
  output logic                 move_tick,
  output logic                 slot_clear,
  output logic [8:0]           dead_times,
  output logic                 game_over
);

  localparam int CD_W = $clog2(COOLDOWN + 1);

  state_t               state, state_nxt;
  logic [CD_W-1:0]      cooldown;
  logic [NUM_SLOTS-1:0] free_slots, spawn_sel, hit_live;
  logic                 in_win, spawn_go, tick_en;

  // Sum is formed one bit wider so the saturation compare never sees a wrap.
  function automatic logic [8:0] sat_dead(input logic [8:0] cur);
    logic [9:0] sum;
    sum = {1'b0, cur} + 10'(DEAD_OFFSET);
    if (sum >= 10'(DEAD_MAX)) return 9'(DEAD_MAX);
    return sum[8:0];
  endfunction

  function automatic logic [NUM_SLOTS-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_set    = '0;
        lowest_set[i] = 1'b1;
      end
    end
  endfunction

  assign in_win     = (BG_step > 9'(WIN_LO)) && (BG_step < 9'(WIN_HI));
  assign hit_live   = hit & slot_active;
  assign free_slots = ~slot_active;
  assign spawn_sel  = lowest_set(free_slots);
  assign spawn_go   = !restart &&
                      (((state == ARMED) && (cooldown == '0)) ||
                       ((state == ACTIVE) && !(|hit_live) && (cooldown == '0) &&
                        in_win && (|free_slots)));
  assign tick_en    = !restart && ((state == ARMED) || (state == ACTIVE));

  frame_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .en        (tick_en),
    .move_tick (move_tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (in_win) state_nxt = ARMED;
        ARMED:     if (spawn_go) state_nxt = ACTIVE;
        ACTIVE: begin
          if (|hit_live)                       state_nxt = HIT_FLUSH;
          else if (!spawn_go && (slot_active == '0) && !in_win)
                                               state_nxt = IDLE;
        end
        HIT_FLUSH: state_nxt = (sat_dead(dead_times) >= 9'(DEAD_MAX)) ? GAMEOVER : IDLE;
        GAMEOVER:  state_nxt = GAMEOVER;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Pulses are gated by Reset so a spawn in flight vanishes in the reset cycle.
  always_comb begin
    spawn_pulse = '0;
    if (Reset && spawn_go) spawn_pulse = spawn_sel;
    slot_clear = Reset && (restart || (state == HIT_FLUSH));
    game_over  = (state == GAMEOVER);
  end

  always_ff @(posedge Clk) begin
    if (!Reset || restart) begin
      slot_active <= '0;
      cooldown    <= '0;
      dead_times  <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (spawn_go) begin
            slot_active <= slot_active | spawn_sel;
            cooldown    <= CD_W'(COOLDOWN);
          end
        end
        ACTIVE: begin
          if (|hit_live) slot_active <= '0;
          else slot_active <= (slot_active & ~offscreen) | (spawn_go ? spawn_sel : '0);
          if (spawn_go)                        cooldown <= CD_W'(COOLDOWN);
          else if (move_tick && cooldown != '0) cooldown <= cooldown - 1'b1;
        end
        HIT_FLUSH: begin
          slot_active <= '0;
          cooldown    <= '0;
          dead_times  <= sat_dead(dead_times);
        end
        default: begin
          slot_active <= '0;
          cooldown    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fire_scheduler.sv
// Scenario bench for fire_scheduler: spawn/penalty scoreboard plus inline checks.
module tb_fire_scheduler;
  import fire_sched_pkg::*;

  logic       Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, restart = 1'b0;
  logic [8:0] BG_step = 9'd0;
  logic [1:0] hit = 2'b00, offscreen = 2'b00;
  logic [1:0] slot_active, spawn_pulse;
  logic       move_tick, slot_clear, game_over;
  logic [8:0] dead_times;

  int vectors = 0, miscompares = 0;
  int mt_cnt = 0, fr_cnt = 0, model_dead = 0;
  logic [1:0] obs_spawn[$], exp_spawn[$];
  int         obs_spawn_mt[$];
  logic [8:0] obs_dead[$], exp_dead[$];
  logic [8:0] dead_prev = 9'd0;

  fire_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .BG_step(BG_step),
    .restart(restart), .hit(hit), .offscreen(offscreen),
    .slot_active(slot_active), .spawn_pulse(spawn_pulse), .move_tick(move_tick),
    .slot_clear(slot_clear), .dead_times(dead_times), .game_over(game_over)
  );

  always #5 Clk = ~Clk;
  always #100 frame_clk = ~frame_clk;
  always @(posedge frame_clk) fr_cnt++;

  always @(negedge Clk) begin
    if (move_tick) mt_cnt++;
    if (spawn_pulse != 2'b00) begin
      obs_spawn.push_back(spawn_pulse);
      obs_spawn_mt.push_back(mt_cnt);
    end
    if (dead_times != dead_prev) begin
      obs_dead.push_back(dead_times);
      dead_prev = dead_times;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; restart = 1'b0; hit = 2'b00; offscreen = 2'b00;
    step(); step();
    obs_spawn.delete(); obs_spawn_mt.delete(); exp_spawn.delete();
    obs_dead.delete(); exp_dead.delete();
    model_dead = 0;
    Reset = 1'b1;
  endtask

  task automatic wait_active(input logic [1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (slot_active == want) begin ok = 1'b1; break; end
    end
  endtask

  function automatic int model_hit(input int d);
    return (d + 10 >= 500) ? 500 : d + 10;
  endfunction

  task automatic test_reset();
    BG_step = 9'd300; hit = 2'b11; Reset = 1'b0;
    step(); step();
    @(negedge Clk);
    vectors++; if (slot_active !== 2'b00) begin miscompares++; $display("FAIL reset_slot_active: got %b want 00", slot_active); end
    vectors++; if (spawn_pulse !== 2'b00) begin miscompares++; $display("FAIL reset_spawn: got %b want 00", spawn_pulse); end
    vectors++; if (move_tick !== 1'b0) begin miscompares++; $display("FAIL reset_move_tick: got %b want 0", move_tick); end
    vectors++; if (slot_clear !== 1'b0) begin miscompares++; $display("FAIL reset_slot_clear: got %b want 0", slot_clear); end
    vectors++; if (dead_times !== 9'd0) begin miscompares++; $display("FAIL reset_dead: got %0d want 0", dead_times); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    hit = 2'b00;
  endtask

  task automatic test_window_spawn();
    int m0, m1;
    logic [1:0] got, want;
    bit done;
    BG_step = 9'd300;
    do_reset();
    exp_spawn.push_back(2'b01);
    exp_spawn.push_back(2'b10);
    done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (obs_spawn.size() >= 2) begin done = 1'b1; break; end
    end
    vectors++;
    if (!done) begin
      miscompares++; $display("FAIL window_spawn_timeout: got %0d spawns want 2", obs_spawn.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        got = obs_spawn.pop_front(); want = exp_spawn.pop_front();
        vectors++; if (got !== want) begin miscompares++; $display("FAIL window_spawn_%0d: got %b want %b", k, got, want); end
      end
      m0 = obs_spawn_mt.pop_front(); m1 = obs_spawn_mt.pop_front();
      vectors++; if (m1 - m0 !== 15) begin miscompares++; $display("FAIL cooldown_ticks: got %0d want 15", m1 - m0); end
      vectors++; if (slot_active !== 2'b11) begin miscompares++; $display("FAIL window_both_active: got %b want 11", slot_active); end
    end
  endtask

  task automatic test_outside_window();
    int mt0;
    bit got;
    BG_step = 9'd292;
    do_reset();
    mt0 = mt_cnt;
    repeat (3000) step();
    vectors++; if (obs_spawn.size() !== 0) begin miscompares++; $display("FAIL bg292_spawn: got %0d spawns want 0", obs_spawn.size()); end
    BG_step = 9'd360;
    repeat (3000) step();
    vectors++; if (obs_spawn.size() !== 0) begin miscompares++; $display("FAIL bg360_spawn: got %0d spawns want 0", obs_spawn.size()); end
    vectors++; if (slot_active !== 2'b00) begin miscompares++; $display("FAIL outside_active: got %b want 00", slot_active); end
    vectors++; if (mt_cnt !== mt0) begin miscompares++; $display("FAIL outside_idle_ticks: got %0d move_ticks want 0", mt_cnt - mt0); end
    BG_step = 9'd293;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (spawn_pulse == 2'b01) got = 1'b1;
    end
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL bg293_spawn: got %b want 1", got); end
  endtask

  task automatic test_hit_penalty();
    bit ok;
    logic [8:0] od, ed;
    BG_step = 9'd300;
    do_reset();
    wait_active(2'b01, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL hit_arm: got %b want 01", slot_active); end
    hit = 2'b11;
    model_dead = model_hit(model_dead);
    exp_dead.push_back(9'(model_dead));
    step();
    hit = 2'b00;
    @(negedge Clk);
    vectors++; if (slot_clear !== 1'b1) begin miscompares++; $display("FAIL flush_clear: got %b want 1", slot_clear); end
    vectors++; if (slot_active !== 2'b00) begin miscompares++; $display("FAIL flush_active: got %b want 00", slot_active); end
    step();
    @(negedge Clk);
    vectors++; if (slot_clear !== 1'b0) begin miscompares++; $display("FAIL flush_one_cycle: got %b want 0", slot_clear); end
    vectors++; if (spawn_pulse !== 2'b00) begin miscompares++; $display("FAIL after_flush_idle: got %b want 00", spawn_pulse); end
    vectors++; if (dead_times !== 9'd10) begin miscompares++; $display("FAIL hit_dead: got %0d want 10", dead_times); end
    step();
    vectors++;
    if (obs_dead.size() != 1) begin
      miscompares++; $display("FAIL hit_dead_events: got %0d changes want 1", obs_dead.size());
    end else begin
      od = obs_dead.pop_front(); ed = exp_dead.pop_front();
      if (od !== ed) begin miscompares++; $display("FAIL hit_dead_sb: got %0d want %0d", od, ed); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [8:0] od, ed;
    BG_step = 9'd300;
    do_reset();
    for (int n = 0; n < 50; n++) begin
      wait_active(2'b01, 20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL sat_arm_%0d: got %b want 01", n, slot_active); end
      hit = 2'b11;
      model_dead = model_hit(model_dead);
      exp_dead.push_back(9'(model_dead));
      step(); hit = 2'b00; step(); step();
      vectors++;
      if (obs_dead.size() == 0) begin
        miscompares++; $display("FAIL sat_dead_%0d: no change seen want %0d", n, model_dead);
      end else begin
        od = obs_dead.pop_front(); ed = exp_dead.pop_front();
        if (od !== ed) begin miscompares++; $display("FAIL sat_dead_%0d: got %0d want %0d", n, od, ed); end
      end
      if (n == 48) begin
        vectors++; if (dead_times !== 9'd490) begin miscompares++; $display("FAIL dead_490: got %0d want 490", dead_times); end
      end
    end
    @(negedge Clk);
    vectors++; if (dead_times !== 9'd500) begin miscompares++; $display("FAIL dead_500: got %0d want 500", dead_times); end
    vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL game_over_set: got %b want 1", game_over); end
    hit = 2'b11;
    repeat (5) step();
    @(negedge Clk);
    vectors++; if (dead_times !== 9'd500) begin miscompares++; $display("FAIL gameover_hit_ignored: got %0d want 500", dead_times); end
    vectors++; if (slot_active !== 2'b00) begin miscompares++; $display("FAIL gameover_active: got %b want 00", slot_active); end
    vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL game_over_hold: got %b want 1", game_over); end
    hit = 2'b00; BG_step = 9'd0;
    step();
    restart = 1'b1;
    @(negedge Clk);
    vectors++; if (slot_clear !== 1'b1) begin miscompares++; $display("FAIL restart_clear: got %b want 1", slot_clear); end
    step();
    restart = 1'b0;
    @(negedge Clk);
    vectors++; if (dead_times !== 9'd0) begin miscompares++; $display("FAIL restart_dead: got %0d want 0", dead_times); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL restart_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_offscreen_vs_hit();
    bit ok;
    logic [8:0] od, ed;
    BG_step = 9'd300;
    do_reset();
    wait_active(2'b01, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL off_arm: got %b want 01", slot_active); end
    offscreen = 2'b01;
    step();
    offscreen = 2'b00;
    vectors++; if (slot_active !== 2'b00) begin miscompares++; $display("FAIL off_free: got %b want 00", slot_active); end
    vectors++; if (dead_times !== 9'(model_dead)) begin miscompares++; $display("FAIL off_no_penalty: got %0d want %0d", dead_times, model_dead); end
    BG_step = 9'd0;
    repeat (3) step();
    BG_step = 9'd300;
    wait_active(2'b01, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL off_rearm: got %b want 01", slot_active); end
    offscreen = 2'b01; hit = 2'b01;
    model_dead = model_hit(model_dead);
    exp_dead.push_back(9'(model_dead));
    step();
    offscreen = 2'b00; hit = 2'b00;
    @(negedge Clk);
    vectors++; if (slot_clear !== 1'b1) begin miscompares++; $display("FAIL off_hit_flush: got %b want 1", slot_clear); end
    step(); step();
    vectors++;
    if (obs_dead.size() != 1) begin
      miscompares++; $display("FAIL off_hit_events: got %0d changes want 1", obs_dead.size());
    end else begin
      od = obs_dead.pop_front(); ed = exp_dead.pop_front();
      if (od !== ed) begin miscompares++; $display("FAIL off_hit_dead: got %0d want %0d", od, ed); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    int fr0, frames;
    BG_step = 9'd300;
    do_reset();
    wait_active(2'b11, 5000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mid_two_live: got %b want 11", slot_active); end
    Reset = 1'b0;
    step();
    @(negedge Clk);
    vectors++; if (slot_active !== 2'b00) begin miscompares++; $display("FAIL mid_active: got %b want 00", slot_active); end
    vectors++; if (spawn_pulse !== 2'b00) begin miscompares++; $display("FAIL mid_spawn: got %b want 00", spawn_pulse); end
    vectors++; if (move_tick !== 1'b0) begin miscompares++; $display("FAIL mid_move_tick: got %b want 0", move_tick); end
    vectors++; if (slot_clear !== 1'b0) begin miscompares++; $display("FAIL mid_slot_clear: got %b want 0", slot_clear); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL mid_game_over: got %b want 0", game_over); end
    step();
    Reset = 1'b1;
    fr0 = fr_cnt; got = 1'b0; frames = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (move_tick) begin got = 1'b1; frames = fr_cnt - fr0; break; end
    end
    vectors++; if (!got) begin miscompares++; $display("FAIL mid_tick_timeout: got none want one"); end
    vectors++; if (frames < TICK_DIV_DEF - 1 || frames > TICK_DIV_DEF) begin
      miscompares++; $display("FAIL mid_tick_delay: got %0d frames want %0d..%0d", frames, TICK_DIV_DEF - 1, TICK_DIV_DEF);
    end
  endtask

  initial begin
    test_reset();
    test_window_spawn();
    test_outside_window();
    test_hit_penalty();
    test_saturation();
    test_offscreen_vs_hit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
